// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state codes, opcodes, datapath select encodings and decode helper for multicycle_ctrl
package ctrl_pkg;
  typedef logic [3:0] state_t;
  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMREAD  = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWRITE = 4'd5;
  localparam state_t S_EXEC_R   = 4'd6;
  localparam state_t S_EXEC_I   = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_BRANCH   = 4'd9;
  localparam state_t S_JALR     = 4'd10;
  localparam state_t S_JUMP     = 4'd11;
  localparam state_t S_UPPER    = 4'd12;
  localparam state_t S_TRAP     = 4'd13;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  function automatic state_t decode_next(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE: decode_next = S_MEMADR;
      OP_R:              decode_next = S_EXEC_R;
      OP_I:              decode_next = S_EXEC_I;
      OP_BRANCH:         decode_next = S_BRANCH;
      OP_JAL:            decode_next = S_JUMP;
      OP_JALR:           decode_next = S_JALR;
      OP_LUI, OP_AUIPC:  decode_next = S_UPPER;
      default:           decode_next = S_TRAP;
    endcase
  endfunction
endpackage

// File: rtl/branch_cond.sv
// branch_cond: RV32I branch taken decision from funct3 and the ALU zero/lt flags
module branch_cond (
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  output logic       taken
);
  always_comb taken = funct3[2] ? (lt ^ funct3[0]) : (!funct3[1] && (zero ^ funct3[0]));
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I sequencing FSM driving datapath strobes, selects and the memory handshake
// Performance counters are built only when CTRL_PERF_CNT_EN is defined.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        zero,
  input  logic        lt,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  result_src,
  output logic [2:0]  imm_src,
  output logic        illegal,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);
  import ctrl_pkg::*;
  state_t state_q, state_d;
  logic   run_q, illegal_q, illegal_d, taken;
  logic   mem_req_c, mem_we_c, ir_write_c, pc_write_c, reg_write_c;
  branch_cond u_branch_cond (
    .funct3 (funct3),
    .zero   (zero),
    .lt     (lt),
    .taken  (taken)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = (run_q && mem_ready) ? S_DECODE : S_FETCH;
      S_DECODE:   state_d = decode_next(op);
      S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_MEMWB, S_ALUWB, S_BRANCH, S_UPPER: state_d = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_JUMP: state_d = S_ALUWB;
      S_JALR:     state_d = S_JUMP;
      default:    state_d = state_q;
    endcase
    illegal_d = illegal_q || (state_d == S_TRAP);
  end
  // run_q holds off the first request until one edge after reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      run_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      illegal_q <= illegal_d;
    end
  end
  always_comb begin
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RD2;
    alu_op      = ALU_ADD;
    result_src  = RES_ALUOUT;
    imm_src     = IMM_I;
    case (state_q)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = (op == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src   = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        adr_src   = 1'b1;
      end
      S_MEMWB: begin
        result_src  = RES_DATA;
        reg_write_c = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RD1;
        alu_op    = ALU_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: reg_write_c = 1'b1;
      S_BRANCH: begin
        alu_src_a  = SRCA_RD1;
        alu_op     = ALU_SUB;
        imm_src    = IMM_B;
        pc_write_c = taken;
      end
      S_JALR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
      end
      S_JUMP: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write_c = 1'b1;
      end
      S_UPPER: begin
        alu_src_a   = (op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
        alu_src_b   = SRCB_IMM;
        imm_src     = IMM_U;
        result_src  = RES_ALURESULT;
        reg_write_c = 1'b1;
      end
      default: ;
    endcase
  end
  assign mem_req   = run_q && mem_req_c;
  assign mem_we    = run_q && mem_we_c;
  assign ir_write  = run_q && ir_write_c;
  assign pc_write  = run_q && pc_write_c;
  assign reg_write = run_q && reg_write_c;
  assign illegal   = illegal_q;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d, instret_cnt_q, instret_cnt_d;
  logic        retire;
  always_comb begin
    retire        = (state_d == S_FETCH) &&
                    (state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH, S_UPPER});
    cycle_cnt_d   = (state_q == S_TRAP) ? cycle_cnt_q : cycle_cnt_q + 32'd1;
    instret_cnt_d = instret_cnt_q + {31'd0, retire};
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end
  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed per-cycle strobe/select checks for multicycle_ctrl
module tb_multicycle_ctrl;
  logic        clk = 1'b0, reset_n = 1'b0, zero = 1'b0, lt = 1'b0, mem_ready = 1'b0;
  logic [6:0]  op = '0;
  logic [2:0]  funct3 = '0;
  logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
  logic [2:0]  imm_src;
  logic [31:0] cycle_cnt, instret_cnt;
  logic [5:0]  strb;
  int          n_cmp = 0, n_bad = 0, edges = 0, exp_ret = 0;
`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  // {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write}
  assign strb = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write};
  multicycle_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .op          (op),
    .funct3      (funct3),
    .zero        (zero),
    .lt          (lt),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .adr_src     (adr_src),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .result_src  (result_src),
    .imm_src     (imm_src),
    .illegal     (illegal),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic mr, input logic [5:0] exp);
    mem_ready = mr;
    #1;
    chk(tag, {26'd0, strb}, {26'd0, exp});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
  endtask
  task automatic counters(input string tag);
    chk({tag, "_cyc"}, cycle_cnt, PERF ? edges : 0);
    chk({tag, "_ret"}, instret_cnt, PERF ? exp_ret : 0);
  endtask
  task automatic fetch_decode(input string tag);
    cyc({tag, "_f"}, 1'b1, 6'b100110);
    tick();
    cyc({tag, "_d"}, 1'b1, 6'b000000);
    tick();
  endtask
  task automatic br(input string tag, input logic [2:0] f3, input logic z, input logic l, input logic tk);
    op = 7'b1100011; funct3 = f3; zero = z; lt = l;
    fetch_decode(tag);
    cyc(tag, 1'b1, {4'b0000, tk, 1'b0});
    chk({tag, "_aluop"}, alu_op, 2'b01);
    tick();
    exp_ret++;
  endtask
  initial begin
    #12;
    chk("rst_strb", strb, 0);
    chk("rst_illegal", illegal, 0);
    counters("rst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    edges = 0;
    cyc("prerun", 1'b1, 6'b000000);
    tick();
    op = 7'b0010011; funct3 = 3'b000;
    cyc("addi_f", 1'b1, 6'b100110);
    chk("addi_f_srcb", alu_src_b, 2'b10);
    chk("addi_f_res", result_src, 2'b10);
    tick();
    cyc("addi_d", 1'b1, 6'b000000);
    chk("addi_d_srca", alu_src_a, 2'b01);
    chk("addi_d_imm", imm_src, 3'b010);
    tick();
    cyc("addi_x", 1'b1, 6'b000000);
    chk("addi_x_aluop", alu_op, 2'b10);
    chk("addi_x_srca", alu_src_a, 2'b10);
    chk("addi_x_srcb", alu_src_b, 2'b01);
    tick();
    cyc("addi_wb", 1'b1, 6'b000001);
    chk("addi_wb_res", result_src, 2'b00);
    tick();
    exp_ret = 1;
    counters("addi");
    op = 7'b0000011;
    fetch_decode("lw");
    cyc("lw_ma", 1'b1, 6'b000000);
    chk("lw_ma_imm", imm_src, 3'b000);
    tick();
    cyc("lw_w0", 1'b0, 6'b101000);
    tick();
    cyc("lw_w1", 1'b0, 6'b101000);
    tick();
    cyc("lw_rd", 1'b1, 6'b101000);
    tick();
    cyc("lw_wb", 1'b1, 6'b000001);
    chk("lw_wb_res", result_src, 2'b01);
    tick();
    exp_ret++;
    op = 7'b0100011;
    fetch_decode("sw");
    cyc("sw_ma", 1'b1, 6'b000000);
    chk("sw_ma_imm", imm_src, 3'b001);
    tick();
    cyc("sw_mw", 1'b1, 6'b111000);
    tick();
    exp_ret++;
    br("beq_t", 3'b000, 1'b1, 1'b0, 1'b1);
    br("beq_n", 3'b000, 1'b0, 1'b0, 1'b0);
    br("bltu_t", 3'b110, 1'b0, 1'b1, 1'b1);
    br("b010", 3'b010, 1'b1, 1'b1, 1'b0);
    br("bge_t", 3'b101, 1'b0, 1'b0, 1'b1);
    br("bne_n", 3'b001, 1'b1, 1'b0, 1'b0);
    op = 7'b1100111;
    fetch_decode("jalr");
    cyc("jalr_x", 1'b1, 6'b000000);
    chk("jalr_x_imm", imm_src, 3'b000);
    tick();
    cyc("jalr_j", 1'b1, 6'b000010);
    chk("jalr_j_res", result_src, 2'b00);
    chk("jalr_j_srca", alu_src_a, 2'b01);
    chk("jalr_j_srcb", alu_src_b, 2'b10);
    tick();
    cyc("jalr_wb", 1'b1, 6'b000001);
    tick();
    exp_ret++;
    op = 7'b1101111;
    cyc("jal_f", 1'b1, 6'b100110);
    tick();
    cyc("jal_d", 1'b1, 6'b000000);
    chk("jal_d_imm", imm_src, 3'b011);
    tick();
    cyc("jal_j", 1'b1, 6'b000010);
    tick();
    cyc("jal_wb", 1'b1, 6'b000001);
    tick();
    exp_ret++;
    op = 7'b0110111;
    fetch_decode("lui");
    cyc("lui_u", 1'b1, 6'b000001);
    chk("lui_srca", alu_src_a, 2'b11);
    chk("lui_imm", imm_src, 3'b100);
    chk("lui_res", result_src, 2'b10);
    tick();
    exp_ret++;
    op = 7'b0010111;
    fetch_decode("auipc");
    cyc("auipc_u", 1'b1, 6'b000001);
    chk("auipc_srca", alu_src_a, 2'b01);
    tick();
    exp_ret++;
    counters("seq");
    chk("seq_illegal", illegal, 0);
    op = 7'b0100011;
    fetch_decode("swr");
    cyc("swr_ma", 1'b1, 6'b000000);
    tick();
    cyc("swr_wait", 1'b0, 6'b111000);
    #1 reset_n = 1'b0;
    #1 chk("rst_async", strb, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    edges = 0;
    exp_ret = 0;
    counters("post_rst");
    cyc("rel_pre", 1'b0, 6'b000000);
    tick();
    cyc("rel_fwait", 1'b0, 6'b100000);
    tick();
    fetch_decode("rel");
    cyc("rel_ma", 1'b1, 6'b000000);
    tick();
    cyc("rel_mw", 1'b1, 6'b111000);
    tick();
    exp_ret = 1;
    counters("rel");
    op = 7'b1111111;
    fetch_decode("trap");
    for (int i = 0; i < 20; i++) begin
      cyc("trap_strb", i[0], 6'b000000);
      chk("trap_illegal", illegal, 1);
      @(posedge clk); #1;
    end
    counters("trap");
    #2 reset_n = 1'b0;
    #1;
    chk("trap_rst_illegal", illegal, 0);
    chk("trap_rst_strb", strb, 0);
    edges = 0;
    exp_ret = 0;
    counters("trap_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
